// File: rtl/mem_arbiter_pkg.sv
// Shared widths and state encodings for the two-client memory arbiter.
package mem_arbiter_pkg;

  localparam int WORD_SIZE  = 16;
  localparam int QWORD_SIZE = 64;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BUSY    = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  // Round-robin pick: on a tie the client that did not win last time goes.
  function automatic logic pick_winner(input logic req0, input logic req1,
                                       input logic last_grant);
    return (req0 && req1) ? ~last_grant : ~req0;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the I-cache (client 0) and D-cache (client 1) onto one memory port.
// One request is latched at a time and forwarded from registers only.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int WORD_W = WORD_SIZE,
  parameter int LINE_W = QWORD_SIZE
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              c0_read_m,
  input  logic              c0_write_m,
  input  logic [WORD_W-1:0] c0_addr,
  input  logic [WORD_W-1:0] c0_size,
  input  logic [LINE_W-1:0] c0_wdata,
  output logic [LINE_W-1:0] c0_rdata,
  output logic              c0_ack,
  input  logic              c1_read_m,
  input  logic              c1_write_m,
  input  logic [WORD_W-1:0] c1_addr,
  input  logic [WORD_W-1:0] c1_size,
  input  logic [LINE_W-1:0] c1_wdata,
  output logic [LINE_W-1:0] c1_rdata,
  output logic              c1_ack,
  output logic              idle,
  output logic              m_read_m,
  output logic              m_write_m,
  output logic [WORD_W-1:0] m_addr,
  output logic [WORD_W-1:0] m_size,
  output logic [LINE_W-1:0] m_wdata,
  input  logic [LINE_W-1:0] m_rdata,
  input  logic              m_ready,
  input  logic              m_ack
);

  logic [1:0]        state;
  logic              last_grant;
  logic              win_id;
  logic              win_write;
  logic              c0_req;
  logic              c1_req;
  logic              grant_id;
  logic              sel_write;
  logic [WORD_W-1:0] sel_addr;
  logic [WORD_W-1:0] sel_size;
  logic [LINE_W-1:0] sel_wdata;

  always_comb begin
    c0_req    = c0_read_m | c0_write_m;
    c1_req    = c1_read_m | c1_write_m;
    grant_id  = pick_winner(c0_req, c1_req, last_grant);
    sel_write = grant_id ? c1_write_m : c0_write_m;
    sel_addr  = grant_id ? c1_addr    : c0_addr;
    sel_size  = grant_id ? c1_size    : c0_size;
    sel_wdata = grant_id ? c1_wdata   : c0_wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      idle       <= 1'b1;
      last_grant <= 1'b1;
      win_id     <= 1'b0;
      win_write  <= 1'b0;
      m_read_m   <= 1'b0;
      m_write_m  <= 1'b0;
      m_addr     <= '0;
      m_size     <= '0;
      m_wdata    <= '0;
      c0_ack     <= 1'b0;
      c1_ack     <= 1'b0;
      c0_rdata   <= '0;
      c1_rdata   <= '0;
    end else begin
      c0_ack <= 1'b0;
      c1_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if ((c0_req || c1_req) && m_ready) begin
            win_id     <= grant_id;
            last_grant <= grant_id;
            win_write  <= sel_write;
            m_read_m   <= ~sel_write;
            m_write_m  <= sel_write;
            m_addr     <= sel_addr;
            m_size     <= sel_size;
            m_wdata    <= sel_wdata;
            state      <= ST_BUSY;
            idle       <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (m_ack) begin
            m_read_m  <= 1'b0;
            m_write_m <= 1'b0;
            if (win_id) c1_ack <= 1'b1;
            else        c0_ack <= 1'b1;
            if (!win_write) begin
              if (win_id) c1_rdata <= m_rdata;
              else        c0_rdata <= m_rdata;
            end
            state <= ST_RELEASE;
          end
        end
        // Grant-free cycle lets the served client drop its held request.
        ST_RELEASE: begin
          state <= ST_IDLE;
          idle  <= 1'b1;
        end
        default: begin
          state     <= ST_IDLE;
          idle      <= 1'b1;
          m_read_m  <= 1'b0;
          m_write_m <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: client/memory agents plus a cycle-timed transaction
// model derived from the arbitration and timing rules.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        c0_read_m, c0_write_m, c1_read_m, c1_write_m;
  logic [15:0] c0_addr, c0_size, c1_addr, c1_size;
  logic [63:0] c0_wdata, c1_wdata, c0_rdata, c1_rdata;
  logic        c0_ack, c1_ack, idle;
  logic        m_read_m, m_write_m, m_ready, m_ack;
  logic [15:0] m_addr, m_size;
  logic [63:0] m_wdata, m_rdata;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .c0_read_m(c0_read_m), .c0_write_m(c0_write_m), .c0_addr(c0_addr),
    .c0_size(c0_size), .c0_wdata(c0_wdata), .c0_rdata(c0_rdata), .c0_ack(c0_ack),
    .c1_read_m(c1_read_m), .c1_write_m(c1_write_m), .c1_addr(c1_addr),
    .c1_size(c1_size), .c1_wdata(c1_wdata), .c1_rdata(c1_rdata), .c1_ack(c1_ack),
    .idle(idle), .m_read_m(m_read_m), .m_write_m(m_write_m), .m_addr(m_addr),
    .m_size(m_size), .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ready(m_ready),
    .m_ack(m_ack)
  );

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h expected=%h", tag, got, exp);
  endtask

  // Reference model: owner of the open transaction and earliest cycle a new grant is legal.
  bit          mdl_on = 1'b0;
  int          cyc = 0;
  int          owner = -1;
  int          last = 1;
  int          ok_at = 0;
  logic        e_rd, e_wr, e_opw, e_idle;
  logic [15:0] e_addr, e_size;
  logic [63:0] e_wdata;
  logic [63:0] e_rdata [2];
  logic        e_ack [2];

  // Agent state
  bit          c0_act = 1'b0, c1_act = 1'b0;
  bit          mem_rand = 1'b0, mem_stray = 1'b0;
  int          mem_cnt = 0, mem_lat = 4;
  logic [63:0] mem_data = '0;
  int          ack_log[$];

  task automatic model_update();
    bit r0, r1;
    int w;
    cyc++;
    e_ack[0] = 1'b0;
    e_ack[1] = 1'b0;
    r0 = c0_read_m | c0_write_m;
    r1 = c1_read_m | c1_write_m;
    if (!reset_n) begin
      mdl_on = 1'b1; owner = -1; last = 1; ok_at = cyc + 1;
      e_rd = 0; e_wr = 0; e_opw = 0; e_addr = '0; e_size = '0; e_wdata = '0;
      e_rdata[0] = '0; e_rdata[1] = '0;
    end else if (mdl_on) begin
      if (owner >= 0 && m_ack) begin
        e_ack[owner] = 1'b1;
        if (!e_opw) e_rdata[owner] = m_rdata;
        e_rd = 0; e_wr = 0; owner = -1; ok_at = cyc + 2;
      end else if (owner < 0 && cyc >= ok_at && m_ready && (r0 || r1)) begin
        w = (r0 && r1) ? 1 - last : (r0 ? 0 : 1);
        owner = w; last = w;
        e_opw   = (w == 0) ? c0_write_m : c1_write_m;
        e_rd    = ~e_opw;
        e_wr    = e_opw;
        e_addr  = (w == 0) ? c0_addr  : c1_addr;
        e_size  = (w == 0) ? c0_size  : c1_size;
        e_wdata = (w == 0) ? c0_wdata : c1_wdata;
      end
    end
    e_idle = (owner < 0) && (cyc + 1 >= ok_at);
  endtask

  task automatic model_check();
    if (mdl_on) begin
      chk("m_read_m", 64'(m_read_m), 64'(e_rd));
      chk("m_write_m", 64'(m_write_m), 64'(e_wr));
      chk("m_addr", 64'(m_addr), 64'(e_addr));
      chk("m_size", 64'(m_size), 64'(e_size));
      chk("m_wdata", m_wdata, e_wdata);
      chk("c0_ack", 64'(c0_ack), 64'(e_ack[0]));
      chk("c1_ack", 64'(c1_ack), 64'(e_ack[1]));
      chk("c0_rdata", c0_rdata, e_rdata[0]);
      chk("c1_rdata", c1_rdata, e_rdata[1]);
      chk("idle", 64'(idle), 64'(e_idle));
    end
  endtask

  task automatic agents();
    m_ack = 1'b0;
    if (c0_act && c0_ack) begin
      c0_read_m = 0; c0_write_m = 0; c0_act = 0; ack_log.push_back(0);
    end
    if (c1_act && c1_ack) begin
      c1_read_m = 0; c1_write_m = 0; c1_act = 0; ack_log.push_back(1);
    end
    if (mem_stray) begin
      m_ack = 1'b1; m_rdata = {$urandom, $urandom}; mem_stray = 0;
    end else if (m_read_m || m_write_m) begin
      if (mem_cnt == 0) mem_cnt = mem_lat;
      mem_cnt--;
      if (mem_cnt == 0) begin
        m_ack = 1'b1;
        m_rdata = mem_rand ? {$urandom, $urandom} : mem_data;
      end
    end else begin
      mem_cnt = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1 model_check();
    @(negedge clk);
    agents();
  endtask

  // op: 0 read, 1 write, 2 both strobes (decodes as write)
  task automatic issue(input int c, input int op, input logic [15:0] a,
                       input logic [15:0] s, input logic [63:0] d);
    if (c == 0) begin
      c0_read_m = (op != 1); c0_write_m = (op != 0);
      c0_addr = a; c0_size = s; c0_wdata = d; c0_act = 1;
    end else begin
      c1_read_m = (op != 1); c1_write_m = (op != 0);
      c1_addr = a; c1_size = s; c1_wdata = d; c1_act = 1;
    end
  endtask

  task automatic do_reset(input int cycles);
    reset_n = 1'b0;
    c0_read_m = 0; c0_write_m = 0; c0_act = 0;
    c1_read_m = 0; c1_write_m = 0; c1_act = 0;
    mem_cnt = 0;
    for (int i = 0; i < cycles; i++) step();
    reset_n = 1'b1;
  endtask

  task automatic wait_quiet(input string tag);
    int n;
    n = 0;
    while ((c0_act || c1_act || !idle) && n < 200) begin
      step();
      n++;
    end
    chk({tag, "_timeout"}, 64'(n < 200), 64'd1);
  endtask

  initial begin
    int n;
    reset_n = 1'b0; m_ready = 1'b1; m_ack = 1'b0; m_rdata = '0;
    c0_read_m = 0; c0_write_m = 0; c0_addr = '0; c0_size = '0; c0_wdata = '0;
    c1_read_m = 0; c1_write_m = 0; c1_addr = '0; c1_size = '0; c1_wdata = '0;

    do_reset(2);
    chk("rst_idle", 64'(idle), 64'd1);
    chk("rst_c0_rdata", c0_rdata, 64'd0);
    chk("rst_strobe", 64'(m_read_m | m_write_m), 64'd0);

    // Lone c0 read, 4-cycle memory
    mem_lat = 4; mem_data = 64'h0004_0003_0002_0001; ack_log.delete();
    issue(0, 0, 16'h0010, 16'd64, 64'd0);
    step();
    chk("t1_strobe", 64'(m_read_m), 64'd1);
    chk("t1_addr", 64'(m_addr), 64'h0010);
    wait_quiet("t1");
    chk("t1_nacks", 64'(ack_log.size()), 64'd1);
    chk("t1_rdata", c0_rdata, 64'h0004_0003_0002_0001);

    // Tie after reset: c0 first, c1 strobe at k+3
    do_reset(1);
    mem_lat = 3; mem_data = 64'h1111_2222_3333_4444;
    issue(0, 0, 16'h0100, 16'd64, 64'd0);
    issue(1, 0, 16'h0200, 16'd64, 64'd0);
    step();
    chk("t2_first", 64'(m_addr), 64'h0100);
    n = 0;
    while (!m_ack && n < 50) begin step(); n++; end
    chk("t2_ack_timeout", 64'(n < 50), 64'd1);
    step();
    chk("t2_c0_ack", 64'(c0_ack), 64'd1);
    chk("t2_k1_strobe", 64'(m_read_m), 64'd0);
    step();
    chk("t2_k2_strobe", 64'(m_read_m), 64'd0);
    step();
    chk("t2_k3_strobe", 64'(m_read_m), 64'd1);
    chk("t2_k3_addr", 64'(m_addr), 64'h0200);
    wait_quiet("t2");

    // Repeated ties alternate c0, c1, c0
    do_reset(1);
    mem_lat = 2; mem_data = 64'hC1C1_C1C1_C1C1_C1C1; ack_log.delete();
    n = 0;
    while (ack_log.size() < 3 && n < 200) begin
      if (!c0_act) issue(0, 0, 16'h0300, 16'd64, 64'd0);
      if (!c1_act) issue(1, 0, 16'h0400, 16'd64, 64'd0);
      step();
      n++;
    end
    chk("t3_count", 64'(ack_log.size() >= 3), 64'd1);
    if (ack_log.size() >= 3) begin
      chk("t3_order0", 64'(ack_log[0]), 64'd0);
      chk("t3_order1", 64'(ack_log[1]), 64'd1);
      chk("t3_order2", 64'(ack_log[2]), 64'd0);
    end
    wait_quiet("t3");
    chk("t3_c1_rdata", c1_rdata, 64'hC1C1_C1C1_C1C1_C1C1);

    // c1 write leaves c1_rdata untouched
    mem_data = 64'hDEAD_DEAD_DEAD_DEAD; ack_log.delete();
    issue(1, 1, 16'h0022, 16'd16, 64'h0000_0000_0000_BEEF);
    step();
    chk("t4_write", 64'(m_write_m), 64'd1);
    chk("t4_read", 64'(m_read_m), 64'd0);
    chk("t4_size", 64'(m_size), 64'd16);
    chk("t4_wdata", m_wdata, 64'h0000_0000_0000_BEEF);
    wait_quiet("t4");
    chk("t4_acked", 64'(ack_log.size() == 1 && ack_log[0] == 1), 64'd1);
    chk("t4_rdata_kept", c1_rdata, 64'hC1C1_C1C1_C1C1_C1C1);

    // Memory not ready holds off the grant
    m_ready = 1'b0;
    issue(0, 2, 16'h0500, 16'd64, 64'h0123_4567_89AB_CDEF);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t5_hold", 64'(m_read_m | m_write_m), 64'd0);
    end
    m_ready = 1'b1;
    step();
    chk("t5_grant", 64'(m_write_m), 64'd1);
    wait_quiet("t5");

    // Reset mid-transaction, stray ack, then a fresh c1 read
    mem_lat = 10; ack_log.delete();
    issue(0, 0, 16'h0600, 16'd64, 64'd0);
    step();
    step();
    chk("t6_busy", 64'(m_read_m), 64'd1);
    do_reset(1);
    chk("t6_strobe", 64'(m_read_m | m_write_m), 64'd0);
    chk("t6_noack", 64'(c0_ack | c1_ack), 64'd0);
    step();
    mem_stray = 1'b1;
    step();
    step();
    chk("t6_stray_ack", 64'(c0_ack | c1_ack), 64'd0);
    chk("t6_stray_idle", 64'(idle), 64'd1);
    chk("t6_nolog", 64'(ack_log.size()), 64'd0);
    mem_lat = 3; mem_data = 64'h5555_AAAA_5555_AAAA;
    issue(1, 0, 16'h0700, 16'd64, 64'd0);
    step();
    chk("t6_grant", 64'(m_read_m), 64'd1);
    chk("t6_addr", 64'(m_addr), 64'h0700);
    wait_quiet("t6");
    chk("t6_rdata", c1_rdata, 64'h5555_AAAA_5555_AAAA);

    // Randomized traffic against the model
    mem_rand = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      m_ready = ($urandom % 5) != 0;
      mem_lat = 1 + int'($urandom % 5);
      if (!c0_act && ($urandom % 3) == 0)
        issue(0, int'($urandom % 3), 16'($urandom), (($urandom % 2) != 0) ? 16'd16 : 16'd64,
              {$urandom, $urandom});
      if (!c1_act && ($urandom % 3) == 0)
        issue(1, int'($urandom % 3), 16'($urandom), (($urandom % 2) != 0) ? 16'd16 : 16'd64,
              {$urandom, $urandom});
      step();
    end
    m_ready = 1'b1;
    wait_quiet("rand");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
